apb_initiator: RTL and testbench
================================

Name: apb_initiator

Overview:
APB4 requester (master) that turns single-beat local-bus commands into APB transfers, for driving CSR blocks generated by the team's register flow.
- Accepts one command at a time through a valid/ready interface and runs the SETUP/ACCESS sequence.
- Honours slave wait states (pready) and captures prdata/pslverr.
- Returns one response per command through a valid/ready interface.
- Sits between firmware-facing bus logic (debug bridge, sequencer) and the APB peripheral segment.

Parameters:
ADDR_W, 16, APB address width
DATA_W, 32, APB data width (32 or 64)
STRB_W, DATA_W/8, write strobe width
TIMEOUT_CYCLES, 256, max ACCESS cycles without pready before abort (used only with the optional feature; >=1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  byte address
cmd_wdata  in  DATA_W  write data
cmd_wstrb  in  STRB_W  write byte strobes
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_err  out  1  pslverr, misalignment or timeout
rsp_timeout  out  1  transfer aborted by timeout
psel, penable, pwrite  out  1 each  APB control
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
pstrb  out  STRB_W  APB strobes
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB error

Behaviour:
- Reset value of every output is 0 (APB outputs, rsp_*), except cmd_ready = 1 (FSM in IDLE). Reset is asynchronous; asserting it mid-transfer drops psel/penable immediately and discards the command and response.
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB outputs and rsp_* are registered.
- IDLE
  - cmd_ready = 1 only in IDLE.
  - On accept, register paddr = cmd_addr, pwrite = cmd_write, pwdata = cmd_wdata.
  - pstrb = cmd_wstrb for writes; pstrb = 0 for reads (APB4 rule).
  - Next state SETUP, unless the command is misaligned (see below).
- Misaligned command (cmd_addr[$clog2(STRB_W)-1:0] != 0): no APB transfer. Next state RESP with rsp_err = 1, rsp_rdata = 0.
- SETUP: psel = 1, penable = 0 in the cycle after accept. Unconditional transition to ACCESS; pready is ignored in SETUP.
- ACCESS
  - psel = 1, penable = 1. paddr, pwrite, pwdata and pstrb are held stable.
  - Each cycle with pready = 0 is a wait state.
  - On pready = 1: rsp_rdata = pwrite ? 0 : prdata; rsp_err = pslverr; rsp_timeout = 0.
  - psel and penable go 0 in the next cycle; next state RESP.
- RESP: rsp_valid = 1. rsp_rdata, rsp_err and rsp_timeout are held until rsp_ready = 1, then IDLE. No psel activity while in RESP.
- Latency: accept at cycle N → psel at N+1, penable at N+2 → rsp_valid at N+3 when there are zero wait states. Minimum 4 cycles per command with rsp_ready tied high.
- Simultaneous rsp_ready and a new cmd_valid in RESP: the response completes; the command is accepted in the following IDLE cycle.
- Between transfers (IDLE/RESP), paddr, pwrite, pwdata and pstrb hold their last values; psel = 0.

Optional Feature:
Macro APB_INITIATOR_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering ACCESS and increments on each ACCESS cycle with pready = 0.
  - When the counter reaches TIMEOUT_CYCLES, the transfer aborts: psel and penable go 0 next cycle, next state RESP with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - pready = 1 in the same cycle as the limit wins: normal completion.
- Not defined: ACCESS waits indefinitely for pready; rsp_timeout is tied to 0; no counter logic.

Decomposition:
- Package apb_initiator_pkg: FSM state enum (IDLE, SETUP, ACCESS, RESP) and a response struct (rdata, err, timeout).
- One natural sub-module, apb_initiator_wdt: the timeout counter with ports clk, rst, clr, tick, expired. It is instantiated only under APB_INITIATOR_TIMEOUT_EN.

Test Plan:
- Write: addr 0x8, wdata 0x31, wstrb 0x1, slave pready = 1 → psel at N+1, penable at N+2, paddr = 0x8, pwdata = 0x31, pstrb = 0x1, rsp_valid at N+3, rsp_err = 0, rsp_rdata = 0.
- Read: addr 0xffc, slave returns prdata 0xcafe0666 after 3 wait states → pstrb = 0, signals stable for 4 ACCESS cycles, rsp_rdata = 0xcafe0666, rsp_err = 0.
- Error: read addr 0x20 with pslverr = 1 on the pready cycle → rsp_err = 1, rsp_timeout = 0.
- Misaligned: write addr 0x6 → psel never asserted, rsp_valid at N+1, rsp_err = 1.
- Backpressure: rsp_ready held low 10 cycles while cmd_valid stays high → cmd_ready = 0 and response held stable; the second command is accepted exactly one cycle after the rsp handshake.
- Timeout (macro defined, TIMEOUT_CYCLES = 16): pready stuck 0 → abort after 16 ACCESS cycles, rsp_err = 1, rsp_timeout = 1; assert rst mid-ACCESS in a rerun → psel = 0 immediately, cmd_ready = 1 after release.

Source files
------------

// File: rtl/apb_initiator_pkg.sv
// Shared types for the APB4 initiator: FSM encoding and the response record.
package apb_initiator_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Response record is sized for the widest supported bus (64 bits);
    // the top slices it down to DATA_W.
    localparam int RSP_DATA_MAX_W = 64;

    typedef struct packed {
        logic [RSP_DATA_MAX_W-1:0] rdata;
        logic                      err;
        logic                      timeout;
    } rsp_t;

endpackage

// File: rtl/apb_initiator_wdt.sv
// ACCESS-phase watchdog: counts wait-state cycles and flags the one that
// would bring the count to LIMIT, so the transfer aborts after exactly LIMIT
// ACCESS cycles without pready.
module apb_initiator_wdt #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tick,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] r_cnt;

    // Clear on the way into ACCESS, count each wait state, saturate at LIMIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (tick && (r_cnt != CNT_W'(LIMIT))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired = tick && (r_cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/apb_initiator.sv
// APB4 requester: one local-bus command in, one APB transfer, one response out.
// Optional ACCESS timeout is built when APB_INITIATOR_TIMEOUT_EN is defined.
import apb_initiator_pkg::*;

module apb_initiator #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int STRB_W         = DATA_W / 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic [STRB_W-1:0] pstrb,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    state_e            r_state;
    logic              r_cmd_ready;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic [STRB_W-1:0] r_pstrb;
    logic              r_rsp_valid;
    rsp_t              r_rsp;

    // Any address bit below the bus word size set means the access is unaligned.
    logic w_misaligned;
    assign w_misaligned = (cmd_addr & ADDR_W'(STRB_W - 1)) != '0;

`ifdef APB_INITIATOR_TIMEOUT_EN
    logic w_wdt_expired;

    apb_initiator_wdt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdt (
        .clk     (clk),
        .rst     (rst),
        .clr     (r_state == SETUP),
        .tick    ((r_state == ACCESS) && !pready),
        .expired (w_wdt_expired)
    );
`endif

    // Main FSM; every APB and response output is a register updated here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_paddr     <= cmd_addr;
                        r_pwrite    <= cmd_write;
                        r_pwdata    <= cmd_wdata;
                        // Reads must drive all-zero strobes on APB4.
                        r_pstrb     <= cmd_write ? cmd_wstrb : '0;
                        r_cmd_ready <= 1'b0;
                        if (w_misaligned) begin
                            r_rsp_valid   <= 1'b1;
                            r_rsp.rdata   <= '0;
                            r_rsp.err     <= 1'b1;
                            r_rsp.timeout <= 1'b0;
                            r_state       <= RESP;
                        end else begin
                            r_psel  <= 1'b1;
                            r_state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp.rdata   <= r_pwrite ? '0 : RSP_DATA_MAX_W'(prdata);
                        r_rsp.err     <= pslverr;
                        r_rsp.timeout <= 1'b0;
                        r_state       <= RESP;
                    end
`ifdef APB_INITIATOR_TIMEOUT_EN
                    else if (w_wdt_expired) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp.rdata   <= '0;
                        r_rsp.err     <= 1'b1;
                        r_rsp.timeout <= 1'b1;
                        r_state       <= RESP;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign pstrb     = r_pstrb;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp.rdata[DATA_W-1:0];
    assign rsp_err   = r_rsp.err;

`ifdef APB_INITIATOR_TIMEOUT_EN
    assign rsp_timeout = r_rsp.timeout;
`else
    assign rsp_timeout = 1'b0;
`endif

    // Upper record bits (narrow bus) and the timeout flag (feature off) are
    // never read; fold them here so they are visibly accounted for.
    logic w_unused_rsp;
    assign w_unused_rsp = ^{r_rsp.rdata, r_rsp.timeout};

endmodule

// File: tb/tb_apb_initiator.sv
// Directed bench for apb_initiator: write, read with wait states, slave error,
// misaligned command, response backpressure, mid-transfer reset and (when
// APB_INITIATOR_TIMEOUT_EN is defined) the ACCESS timeout.
module tb_apb_initiator;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    int n_checks = 0;
    int n_errors = 0;

    apb_initiator #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .STRB_W         (STRB_W),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
    endtask

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;

        // ---- reset state
        step();
        step();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_rsp_err", rsp_err, 0);
        rst = 1'b1;
        step();

        // ---- write, zero wait states (cycle N = accept)
        send(1'b1, 16'h0008, 32'h31, 4'h1);
        pready    = 1'b1;
        rsp_ready = 1'b1;
        step();                                         // N+1
        cmd_valid = 1'b0;
        chk("wr_setup_psel", psel, 1);
        chk("wr_setup_penable", penable, 0);
        chk("wr_cmd_ready", cmd_ready, 0);
        chk("wr_paddr", paddr, 16'h0008);
        chk("wr_pwdata", pwdata, 32'h31);
        chk("wr_pstrb", pstrb, 4'h1);
        chk("wr_pwrite", pwrite, 1);
        step();                                         // N+2
        chk("wr_access_psel", psel, 1);
        chk("wr_access_penable", penable, 1);
        chk("wr_rsp_early", rsp_valid, 0);
        step();                                         // N+3
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_psel_off", psel, 0);
        chk("wr_rsp_err", rsp_err, 0);
        chk("wr_rsp_rdata", rsp_rdata, 0);
        step();                                         // N+4
        chk("wr_rsp_done", rsp_valid, 0);
        chk("wr_idle_ready", cmd_ready, 1);

        // ---- read, three wait states
        send(1'b0, 16'h0ffc, 32'hdeadbeef, 4'hf);
        pready = 1'b0;
        step();                                         // N+1 SETUP
        cmd_valid = 1'b0;
        chk("rd_setup_psel", psel, 1);
        chk("rd_pstrb", pstrb, 0);
        step();                                         // N+2 first ACCESS
        for (int i = 0; i < 4; i++) begin
            chk("rd_access_psel", psel, 1);
            chk("rd_access_penable", penable, 1);
            chk("rd_access_paddr", paddr, 16'h0ffc);
            chk("rd_access_pwrite", pwrite, 0);
            chk("rd_access_pstrb", pstrb, 0);
            chk("rd_access_no_rsp", rsp_valid, 0);
            if (i == 3) begin
                pready = 1'b1;
                prdata = 32'hcafe0666;
            end
            step();
        end
        pready = 1'b0;
        prdata = 32'h0;
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_rdata", rsp_rdata, 32'hcafe0666);
        chk("rd_rsp_err", rsp_err, 0);
        chk("rd_psel_off", psel, 0);
        step();

        // ---- slave error on read
        send(1'b0, 16'h0020, 32'h0, 4'h0);
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'h12345678;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        pslverr = 1'b0;
        chk("err_rsp_valid", rsp_valid, 1);
        chk("err_rsp_err", rsp_err, 1);
        chk("err_rsp_timeout", rsp_timeout, 0);
        chk("err_rsp_rdata", rsp_rdata, 32'h12345678);
        step();

        // ---- misaligned write: no APB activity, response next cycle
        send(1'b1, 16'h0006, 32'h55, 4'hf);
        step();                                         // N+1
        cmd_valid = 1'b0;
        chk("mis_psel", psel, 0);
        chk("mis_rsp_valid", rsp_valid, 1);
        chk("mis_rsp_err", rsp_err, 1);
        chk("mis_rsp_rdata", rsp_rdata, 0);
        step();
        chk("mis_psel_after", psel, 0);
        chk("mis_idle_ready", cmd_ready, 1);

        // ---- response backpressure with a second command waiting
        rsp_ready = 1'b0;
        pready    = 1'b1;
        send(1'b0, 16'h0010, 32'h0, 4'h0);
        prdata = 32'h0000aaaa;
        step();                                         // N+1
        send(1'b1, 16'h0014, 32'h77, 4'h3);
        step();                                         // N+2
        step();                                         // N+3
        prdata = 32'h0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_rdata", rsp_rdata, 32'h0000aaaa);
            chk("bp_psel", psel, 0);
            step();
        end
        rsp_ready = 1'b1;
        step();                                         // handshake taken
        chk("bp_after_rsp", rsp_valid, 0);
        chk("bp_ready_again", cmd_ready, 1);
        step();                                         // second cmd accepted
        cmd_valid = 1'b0;
        chk("bp_2nd_psel", psel, 1);
        chk("bp_2nd_paddr", paddr, 16'h0014);
        chk("bp_2nd_pstrb", pstrb, 4'h3);
        step();
        step();
        chk("bp_2nd_rsp", rsp_valid, 1);
        chk("bp_2nd_rdata", rsp_rdata, 0);
        step();

        // ---- reset asserted in the middle of ACCESS
        pready = 1'b0;
        send(1'b0, 16'h0030, 32'h0, 4'h0);
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("mr_psel_before", psel, 1);
        #2 rst = 1'b0;
        #1;
        chk("mr_psel_async", psel, 0);
        chk("mr_penable_async", penable, 0);
        chk("mr_cmd_ready_async", cmd_ready, 1);
        step();
        rst = 1'b1;
        step();
        chk("mr_cmd_ready_rel", cmd_ready, 1);
        chk("mr_rsp_valid_rel", rsp_valid, 0);
        chk("mr_psel_rel", psel, 0);

`ifdef APB_INITIATOR_TIMEOUT_EN
        // ---- timeout: pready stuck low, limit 16
        send(1'b0, 16'h0040, 32'h0, 4'h0);
        step();                                         // SETUP
        cmd_valid = 1'b0;
        step();                                         // first ACCESS
        for (int i = 0; i < 16; i++) begin
            chk("to_access_penable", penable, 1);
            chk("to_access_no_rsp", rsp_valid, 0);
            step();
        end
        chk("to_psel_off", psel, 0);
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_timeout", rsp_timeout, 1);
        chk("to_rsp_rdata", rsp_rdata, 0);
        step();
        chk("to_idle_ready", cmd_ready, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
